// File: rtl/wt_dcache_mem_bridge.sv
// Write-through dcache memory bridge: request FIFO toward the bus, outstanding-ID tracking, registered return path.
// Optional watchdog (timeout_o) is built when WT_DCACHE_BRIDGE_TIMEOUT_EN is defined.
module wt_dcache_mem_bridge #(
  parameter int unsigned ReqWidth      = 128,
  parameter int unsigned RtrnWidth     = 192,
  parameter int unsigned TidWidth      = 2,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       dc_req_i,
  output logic                       dc_ack_o,
  input  logic [ReqWidth-1:0]        dc_data_i,
  input  logic [TidWidth-1:0]        dc_tid_i,
  output logic                       bus_req_vld_o,
  input  logic                       bus_req_rdy_i,
  output logic [ReqWidth-1:0]        bus_req_o,
  output logic [TidWidth-1:0]        bus_tid_o,
  input  logic                       bus_rtrn_vld_i,
  input  logic [RtrnWidth-1:0]       bus_rtrn_i,
  input  logic [TidWidth-1:0]        bus_rtrn_tid_i,
  output logic                       dc_rtrn_vld_o,
  output logic [RtrnWidth-1:0]       dc_rtrn_o,
  output logic [(2**TidWidth)-1:0]   tid_busy_o,
  output logic                       idle_o,
`ifdef WT_DCACHE_BRIDGE_TIMEOUT_EN
  output logic                       timeout_o,
`endif
  output logic                       err_o
);

  localparam int unsigned NumTid = 2 ** TidWidth;
  localparam int unsigned AddrW  = $clog2(FifoDepth);
  localparam int unsigned PtrW   = AddrW + 1;
  localparam int unsigned EntryW = TidWidth + ReqWidth;

  // Elaboration-time parameter sanity checks
  if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_depth
    $error("FifoDepth must be a power of two >= 2");
  end
  if ((TimeoutCycles < 1) || (TimeoutCycles > 65535)) begin : g_bad_timeout
    $error("TimeoutCycles must fit the 16-bit watchdog");
  end

  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [EntryW-1:0]    mem_q [FifoDepth];
  logic [EntryW-1:0]    head;
  logic [NumTid-1:0]    busy_q, busy_d;
  logic                 fifo_empty, fifo_full;
  logic                 push, pop;
  logic                 rtrn_hit, rtrn_miss;
  logic                 err_q;
  logic                 rtrn_vld_q;
  logic [RtrnWidth-1:0] rtrn_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                      (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign dc_ack_o      = dc_req_i & ~fifo_full & ~busy_q[dc_tid_i] & ~rst_i;
  assign push          = dc_ack_o;
  assign bus_req_vld_o = ~fifo_empty;
  assign pop           = bus_req_vld_o & bus_req_rdy_i;

  assign head      = mem_q[rptr_q[AddrW-1:0]];
  assign bus_tid_o = head[EntryW-1 -: TidWidth];
  assign bus_req_o = head[ReqWidth-1:0];

  assign rtrn_hit  = bus_rtrn_vld_i &  busy_q[bus_rtrn_tid_i];
  assign rtrn_miss = bus_rtrn_vld_i & ~busy_q[bus_rtrn_tid_i];

  // An accept can never target the ID being returned, since that ID still reads busy
  always_comb begin
    busy_d = busy_q;
    if (rtrn_hit) busy_d[bus_rtrn_tid_i] = 1'b0;
    if (push)     busy_d[dc_tid_i]       = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AddrW-1:0]] <= {dc_tid_i, dc_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
      rtrn_vld_q <= 1'b0;
      rtrn_q     <= '0;
    end else begin
      wptr_q     <= wptr_q + PtrW'(push);
      rptr_q     <= rptr_q + PtrW'(pop);
      busy_q     <= busy_d;
      err_q      <= err_q | rtrn_miss;
      rtrn_vld_q <= rtrn_hit;
      if (rtrn_hit) rtrn_q <= bus_rtrn_i;
    end
  end

  assign tid_busy_o    = busy_q;
  assign idle_o        = fifo_empty & ~|busy_q;
  assign err_o         = err_q;
  assign dc_rtrn_vld_o = rtrn_vld_q;
  assign dc_rtrn_o     = rtrn_q;

`ifdef WT_DCACHE_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] WdLimit = 16'(TimeoutCycles);

  logic [15:0] wd_cnt_q;
  logic        timeout_q;

  // Watchdog: counts stalled cycles with work outstanding, saturates at the limit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (~|busy_q || bus_rtrn_vld_i) begin
      wd_cnt_q <= '0;
    end else if (wd_cnt_q != WdLimit) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
      if (wd_cnt_q == WdLimit - 16'd1) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_wt_dcache_mem_bridge.sv
// Self-checking bench for wt_dcache_mem_bridge: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Define WT_DCACHE_BRIDGE_TIMEOUT_EN to cover the watchdog.
module tb_wt_dcache_mem_bridge;

  localparam int unsigned RqW   = 128;
  localparam int unsigned RtW   = 192;
  localparam int unsigned TidW  = 2;
  localparam int unsigned NT    = 4;
  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            req;
  logic            ack;
  logic [RqW-1:0]  data;
  logic [TidW-1:0] tid;
  logic            bvld;
  logic            rdy;
  logic [RqW-1:0]  bdata;
  logic [TidW-1:0] btid;
  logic            rvld;
  logic [RtW-1:0]  rdata;
  logic [TidW-1:0] rtid;
  logic            dvld;
  logic [RtW-1:0]  ddata;
  logic [NT-1:0]   busy;
  logic            idle;
  logic            err;
`ifdef WT_DCACHE_BRIDGE_TIMEOUT_EN
  logic            timeout;
`endif

  wt_dcache_mem_bridge #(
    .ReqWidth(RqW), .RtrnWidth(RtW), .TidWidth(TidW), .FifoDepth(Depth), .TimeoutCycles(Tmo)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .dc_req_i(req), .dc_ack_o(ack), .dc_data_i(data), .dc_tid_i(tid),
    .bus_req_vld_o(bvld), .bus_req_rdy_i(rdy), .bus_req_o(bdata), .bus_tid_o(btid),
    .bus_rtrn_vld_i(rvld), .bus_rtrn_i(rdata), .bus_rtrn_tid_i(rtid),
    .dc_rtrn_vld_o(dvld), .dc_rtrn_o(ddata), .tid_busy_o(busy), .idle_o(idle),
`ifdef WT_DCACHE_BRIDGE_TIMEOUT_EN
    .timeout_o(timeout),
`endif
    .err_o(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO as a queue of {tid,data}, busy bitmap, return register, watchdog
  typedef struct packed {
    logic [TidW-1:0] tid;
    logic [RqW-1:0]  data;
  } ent_t;

  ent_t           q[$];
  logic [NT-1:0]  m_busy;
  logic           m_err, m_rv, m_tmo;
  logic [RtW-1:0] m_rd;
  int             m_wd;
  bit             mon_en = 1'b0;

  always @(posedge clk) begin
    logic acc, pp, hit, miss;
    if (rst) begin
      q.delete();
      m_busy = '0; m_err = 1'b0; m_rv = 1'b0; m_rd = '0; m_wd = 0; m_tmo = 1'b0;
    end else begin
      acc  = req && (q.size() < Depth) && !m_busy[tid];
      pp   = (q.size() != 0) && rdy;
      hit  = rvld && m_busy[rtid];
      miss = rvld && !m_busy[rtid];
      if ((m_busy != 0) && !rvld) begin
        if (m_wd < Tmo) m_wd++;
        if (m_wd == Tmo) m_tmo = 1'b1;
      end else begin
        m_wd = 0;
      end
      if (pp) void'(q.pop_front());
      if (acc) q.push_back('{tid: tid, data: data});
      if (hit) m_busy[rtid] = 1'b0;
      if (acc) m_busy[tid] = 1'b1;
      m_err = m_err | miss;
      m_rv  = hit;
      if (hit) m_rd = rdata;
    end
  end

  // Compare process: every output against the model, away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      check("ack", ack, req && !rst && (q.size() < Depth) && !m_busy[tid]);
      check("bus_vld", bvld, q.size() != 0);
      if (q.size() != 0) begin
        check("bus_tid", btid, q[0].tid);
        check("bus_data", bdata, q[0].data);
      end
      check("tid_busy", busy, m_busy);
      check("idle", idle, (q.size() == 0) && (m_busy == 0));
      check("err", err, m_err);
      check("rtrn_vld", dvld, m_rv);
      if (m_rv) check("rtrn_data", ddata, m_rd);
`ifdef WT_DCACHE_BRIDGE_TIMEOUT_EN
      check("timeout", timeout, m_tmo);
`endif
    end
  end

  task automatic wait_ack(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      got = ack;
      step();
    end
    check(name, got, 1);
  endtask

  int          sent;
  bit          pend, done, got, pop_now;
  logic [TidW-1:0] ptid, ptid_n;

  initial begin
    rst = 1'b1; req = 1'b0; tid = '0; data = '0; rdy = 1'b0;
    rvld = 1'b0; rtid = '0; rdata = '0;
    step(); step();
    mon_en = 1'b1;
    check("rst_idle", idle, 1);
    check("rst_busy", busy, 0);
    check("rst_rvld", dvld, 0);
    check("rst_rdata", ddata, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Single request flows straight through
    req = 1'b1; tid = 2'd1; data = 128'hA5; rdy = 1'b1;
    #1 check("t1_ack", ack, 1);
    step();
    req = 1'b0;
    check("t1_bvld", bvld, 1);
    check("t1_btid", btid, 1);
    check("t1_bdata", bdata, 128'hA5);
    check("t1_busy", busy, 4'b0010);
    step();

    // Return tid1, then fill the FIFO with ready low
    rdy = 1'b0; rvld = 1'b1; rtid = 2'd1; rdata = 192'hBEEF;
    step();
    rvld = 1'b0;
    check("t2_rvld", dvld, 1);
    check("t2_rdata", ddata, 192'hBEEF);
    step();
    check("t2_pulse_end", dvld, 0);
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; tid = 2'(i); data = 128'h100 + 128'(i);
      #1 check("t2_ack", ack, 1);
      step();
    end
    req = 1'b0; rvld = 1'b1; rtid = 2'd0; rdata = 192'h0;
    step();
    rvld = 1'b0;
    req = 1'b1; tid = 2'd0; data = 128'h200;
    for (int k = 0; k < 3; k++) begin
      #1 check("t2_full_noack", ack, 0);
      check("t2_head", btid, 0);
      step();
    end
    rdy = 1'b1;
    wait_ack("t2_held_ack");
    req = 1'b0;
    repeat (6) step();

    // Busy ID held off until its return frees it
    req = 1'b1; tid = 2'd2; data = 128'h300;
    #1 check("t3_noack", ack, 0);
    rvld = 1'b1; rtid = 2'd2; rdata = 192'h1234;
    step();
    rvld = 1'b0;
    check("t3_rvld", dvld, 1);
    check("t3_rdata", ddata, 192'h1234);
    check("t3_ack_next", ack, 1);
    step();
    req = 1'b0;
    step();

    // Unexpected return sets sticky err
    rvld = 1'b1; rtid = 2'd3; rdata = 192'h33;
    step();
    rvld = 1'b1; rtid = 2'd3; rdata = 192'h44;
    step();
    rvld = 1'b0;
    check("t4_err", err, 1);
    check("t4_no_rvld", dvld, 0);
    repeat (5) step();
    check("t4_err_sticky", err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_err_clr", err, 0);
    check("t4_idle", idle, 1);
    check("t4_busy", busy, 0);

    // Steady push+pop at count 2 across pointer wrap, returns follow each pop
    sent = 0; pend = 1'b0; done = 1'b0; ptid = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      req = (sent < 8); tid = 2'(sent % 4); data = 128'hC0DE0000 + 128'(sent);
      rdy = (sent >= 2);
      rvld = pend; rtid = ptid; rdata = 192'hD000 + 192'(ptid);
      #1;
      if (sent == 8 && idle && !pend) begin
        done = 1'b1;
      end else begin
        got = ack; pop_now = bvld & rdy; ptid_n = btid;
        step();
        if (got) sent++;
        pend = pop_now; ptid = ptid_n;
      end
    end
    req = 1'b0; rvld = 1'b0;
    check("t5_sent", sent, 8);
    check("t5_done", done, 1);
    step();

`ifdef WT_DCACHE_BRIDGE_TIMEOUT_EN
    // Watchdog fires after Tmo stalled cycles
    req = 1'b1; tid = 2'd1; data = 128'h77; rdy = 1'b1;
    #1 check("t6_ack", ack, 1);
    step();
    req = 1'b0;
    repeat (15) step();
    check("t6_no_tmo", timeout, 0);
    step();
    check("t6_tmo", timeout, 1);
`endif

    // Reset mid-flight discards queued and outstanding work
    req = 1'b1; tid = 2'd2; data = 128'h99; rdy = 1'b0;
    step();
    req = 1'b0;
    check("t6_pre_bvld", bvld, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_idle", idle, 1);
    check("t6_rst_bvld", bvld, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rvld", dvld, 0);
    check("t6_rst_err", err, 0);
`ifdef WT_DCACHE_BRIDGE_TIMEOUT_EN
    check("t6_rst_tmo", timeout, 0);
`endif
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
